// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - control/select bundle between scan_sequencer and its user
interface scan_sequencer_if #(
    parameter int N = 8,
    parameter int M = $clog2(N)
);
    logic         en;
    logic [N-1:0] mask;
    logic [M-1:0] sel;
    logic         active;
    logic         frame;

    modport master (output en, output mask, input sel, input active, input frame);
    modport slave  (input en, input mask, output sel, output active, output frame);
endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - steps a line select through enabled lines with dwell/blank timing
module scan_sequencer #(
    parameter int N     = 8,
    parameter int M     = $clog2(N),
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic            clk,
    input  logic            rst,
    scan_sequencer_if.slave bus
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   sel_q, sel_d;
    logic           active_q, active_d;
    logic           frame_q, frame_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [M-1:0]   low_idx;
    logic [M-1:0]   above_idx;
    logic           any_above;
    logic           mask_any;

    // Descending scan: the last hit is the lowest qualifying bit.
    always_comb begin
        low_idx   = '0;
        above_idx = '0;
        any_above = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.mask[i]) begin
                low_idx = M'(i);
                if (M'(i) > sel_q) begin
                    above_idx = M'(i);
                    any_above = 1'b1;
                end
            end
        end
    end

    assign mask_any = |bus.mask;

    always_comb begin
        logic do_next;
        state_d  = state_q;
        sel_d    = sel_q;
        active_d = active_q;
        frame_d  = 1'b0;
        cnt_d    = cnt_q;
        do_next  = 1'b0;

        if (!bus.en) begin
            state_d  = IDLE;
            active_d = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    active_d = 1'b0;
                    if (mask_any) begin
                        sel_d    = low_idx;
                        active_d = 1'b1;
                        cnt_d    = DWELL_LD;
                        state_d  = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (BLANK > 0) begin
                        active_d = 1'b0;
                        cnt_d    = BLANK_LD;
                        state_d  = GAP;
                    end else begin
                        do_next = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        do_next = 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            endcase

            // A wrap to the lowest line (even the same line) marks a new frame.
            if (do_next) begin
                if (!mask_any) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    sel_d    = any_above ? above_idx : low_idx;
                    frame_d  = ~any_above;
                    active_d = 1'b1;
                    cnt_d    = DWELL_LD;
                    state_d  = SHOW;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            active_q <= 1'b0;
            frame_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.active = active_q;
    assign bus.frame  = frame_q;
endmodule
